bram_message_reader: RTL and testbench

BRAM_MESSAGE_READER -- requirements
Module: bram_message_reader

---
 rtl/msg_pkg.sv | 16 +
 rtl/msg_byte_buffer.sv | 48 ++++
 rtl/bram_message_reader.sv | 116 +++++++++++
 tb/tb_bram_message_reader.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_pkg.sv
// Shared types for the BRAM message reader: FSM states and length-width helper.
package msg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        DONE
    } state_t;

    function automatic int len_width(input int port_width);
        return $clog2(port_width + 1);
    endfunction

endpackage

// File: rtl/msg_byte_buffer.sv
// Two-word byte FIFO: shift out consumed bytes, append a BRAM word behind the
// survivors in the same cycle, and present the masked head chunk.
module msg_byte_buffer
    import msg_pkg::*;
#(
    parameter int PORT_WIDTH = 7,
    localparam int LEN_W = len_width(PORT_WIDTH),
    localparam int CNT_W = $clog2(2 * PORT_WIDTH + 1)
) (
    input  logic                         clk_in,
    input  logic                         clear,
    input  logic                         append_en,
    input  logic [PORT_WIDTH*8-1:0]      append_data,
    input  logic [LEN_W-1:0]             consume_len,
    input  logic [LEN_W-1:0]             mask_len,
    output logic [CNT_W-1:0]             count,
    output logic [PORT_WIDTH-1:0][7:0]   head_bytes
);

    localparam int DEPTH = 2 * PORT_WIDTH;

    logic [DEPTH*8-1:0] buf_q;
    logic [DEPTH*8-1:0] shifted;
    logic [DEPTH*8-1:0] placed;
    logic [CNT_W-1:0]   base;
    logic [CNT_W-1:0]   count_d;

    // Bytes above count are always zero, so OR-ing the new word in is safe.
    assign base    = count - CNT_W'(consume_len);
    assign shifted = buf_q >> {consume_len, 3'b000};
    assign placed  = {{((DEPTH - PORT_WIDTH) * 8){1'b0}}, append_data}
                     << {base, 3'b000};
    assign count_d = base + (append_en ? CNT_W'(PORT_WIDTH) : '0);

    assign head_bytes = buf_q[PORT_WIDTH*8-1:0]
                        & ~({(PORT_WIDTH * 8){1'b1}} << {mask_len, 3'b000});

    always_ff @(posedge clk_in) begin
        if (clear) begin
            buf_q <= '0;
            count <= '0;
        end else begin
            buf_q <= append_en ? (shifted | placed) : shifted;
            count <= count_d;
        end
    end

endmodule

// File: rtl/bram_message_reader.sv
// Streams a BRAM-resident message out as variable-length byte chunks.
// Define MSG_READER_WRAP_EN to replay the message endlessly instead of finishing.
module bram_message_reader
    import msg_pkg::*;
#(
    parameter int PORT_WIDTH   = 7,
    parameter int BRAM_DEPTH   = 1024,
    parameter int BRAM_LATENCY = 2,
    localparam int BRAM_ADDR   = $clog2(BRAM_DEPTH),
    localparam int LEN_W       = len_width(PORT_WIDTH)
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       en_in,
    input  logic [BRAM_ADDR:0]         word_count_in,
    input  logic [LEN_W-1:0]           req_len_in,
    input  logic                       ready_in,
    output logic                       valid_out,
    output logic [PORT_WIDTH-1:0][7:0] data_out,
    output logic [LEN_W-1:0]           length_out,
    output logic                       done_out,
    output logic [BRAM_ADDR-1:0]       bram_addr,
    input  logic [PORT_WIDTH*8-1:0]    bram_dout
);

    localparam int CNT_W = $clog2(2 * PORT_WIDTH + 1);
    localparam int LAT_W = $clog2(BRAM_LATENCY + 1);

    state_t           state_q;
    state_t           fill_state;
    logic [LAT_W-1:0] lat_q;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] consume;
    logic [BRAM_ADDR:0] addr_inc;
    logic             clear;
    logic             capture;
    logic             fire;
    logic             last_word;

    assign clear   = rst_in || !en_in;
    assign capture = (state_q == WAIT)
                     && (lat_q == LAT_W'(BRAM_LATENCY - 1));

    assign len = (count >= CNT_W'(req_len_in)) ? req_len_in : LEN_W'(count);
    assign valid_out = (count >= CNT_W'(req_len_in))
                       || (state_q == DONE && count != '0);
    assign length_out = len;
    assign fire       = valid_out && ready_in;
    assign consume    = fire ? len : '0;

    assign count_next = count - CNT_W'(consume) + CNT_W'(PORT_WIDTH);
    assign fill_state = (count_next <= CNT_W'(PORT_WIDTH)) ? ISSUE : HOLD;
    assign addr_inc   = {1'b0, bram_addr} + (BRAM_ADDR + 1)'(1);
    assign last_word  = (addr_inc == word_count_in);

`ifdef MSG_READER_WRAP_EN
    assign done_out = 1'b0;
`else
    assign done_out = (state_q == DONE) && (count == '0);
`endif

    msg_byte_buffer #(
        .PORT_WIDTH(PORT_WIDTH)
    ) u_buf (
        .clk_in     (clk_in),
        .clear      (clear),
        .append_en  (capture),
        .append_data(bram_dout),
        .consume_len(consume),
        .mask_len   (len),
        .count      (count),
        .head_bytes (data_out)
    );

    always_ff @(posedge clk_in) begin
        if (clear) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            bram_addr <= '0;
        end else begin
            unique case (state_q)
                IDLE: state_q <= (word_count_in == '0) ? DONE : ISSUE;
                ISSUE: begin
                    lat_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (capture) begin
                        if (last_word) begin
`ifdef MSG_READER_WRAP_EN
                            bram_addr <= '0;
                            state_q   <= fill_state;
`else
                            bram_addr <= addr_inc[BRAM_ADDR-1:0];
                            state_q   <= DONE;
`endif
                        end else begin
                            bram_addr <= addr_inc[BRAM_ADDR-1:0];
                            state_q   <= fill_state;
                        end
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                HOLD: begin
                    if (count <= CNT_W'(PORT_WIDTH)) state_q <= ISSUE;
                end
                DONE: state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_message_reader.sv
// Directed bench for bram_message_reader with a 2-cycle BRAM model.
module tb_bram_message_reader;
    import msg_pkg::*;

    localparam int PW = 7;
    localparam int AW = 10;
    localparam int LW = 3;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic                 rst_in = 1'b1;
    logic                 en_in = 1'b0;
    logic [AW:0]          word_count_in = '0;
    logic [LW-1:0]        req_len_in = 3'd7;
    logic                 ready_in = 1'b0;
    logic                 valid_out;
    logic [PW-1:0][7:0]   data_out;
    logic [LW-1:0]        length_out;
    logic                 done_out;
    logic [AW-1:0]        bram_addr;
    logic [PW*8-1:0]      bram_dout;

    int checks = 0;
    int errors = 0;

    logic [7:0]         got_q[$];
    int                 len_q[$];
    logic [PW-1:0][7:0] dat_q[$];

    bram_message_reader #(
        .PORT_WIDTH(PW),
        .BRAM_DEPTH(1024),
        .BRAM_LATENCY(2)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .en_in        (en_in),
        .word_count_in(word_count_in),
        .req_len_in   (req_len_in),
        .ready_in     (ready_in),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .length_out   (length_out),
        .done_out     (done_out),
        .bram_addr    (bram_addr),
        .bram_dout    (bram_dout)
    );

    // Word w holds bytes w*7 .. w*7+6.
    function automatic logic [PW*8-1:0] word_of(input logic [AW-1:0] a);
        logic [PW*8-1:0] w;
        for (int b = 0; b < PW; b++) w[b*8 +: 8] = 8'(int'(a) * PW + b);
        return w;
    endfunction

    logic [PW*8-1:0] pipe0, pipe1;
    always_ff @(posedge clk_in) begin
        pipe0 <= word_of(bram_addr);
        pipe1 <= pipe0;
    end
    assign bram_dout = pipe1;

    task automatic tick();
        #1;
        if (valid_out && ready_in) begin
            len_q.push_back(int'(length_out));
            dat_q.push_back(data_out);
            for (int i = 0; i < int'(length_out); i++) got_q.push_back(data_out[i]);
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic restart(input int wc, input int rl, input logic rdy);
        rst_in = 1'b1;
        en_in = 1'b1;
        word_count_in = 11'(wc);
        req_len_in = 3'(rl);
        ready_in = rdy;
        tick();
        rst_in = 1'b0;
        got_q.delete();
        len_q.delete();
        dat_q.delete();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (!done_out && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        en_in = 1'b1;
        word_count_in = 11'd3;
        ready_in = 1'b1;
        tick();
        tick();
        checks++;
        if (bram_addr !== '0) begin
            errors++; $display("FAIL reset_addr got=%0d exp=0", bram_addr);
        end
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_valid got=%0b exp=0", valid_out);
        end
        checks++;
        if (data_out !== '0) begin
            errors++; $display("FAIL reset_data got=%h exp=0", data_out);
        end
        checks++;
        if (length_out !== '0) begin
            errors++; $display("FAIL reset_len got=%0d exp=0", length_out);
        end
        checks++;
        if (done_out !== 1'b0) begin
            errors++; $display("FAIL reset_done got=%0b exp=0", done_out);
        end
    endtask

    task automatic test_empty();
        restart(0, 7, 1'b1);
        tick();
        checks++;
        if (done_out !== 1'b1) begin
            errors++; $display("FAIL empty_done got=%0b exp=1", done_out);
        end
        checks++;
        if (bram_addr !== '0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL empty_idle addr=%0d valid=%0b exp addr=0 valid=0",
                     bram_addr, valid_out);
        end
    endtask

    task automatic test_basic();
        logic [PW-1:0][7:0] exp;
        restart(3, 7, 1'b1);
        drain(80);
        checks++;
        if (len_q.size() != 3) begin
            errors++; $display("FAIL basic_chunks got=%0d exp=3", len_q.size());
        end
        for (int k = 0; k < 3 && k < dat_q.size(); k++) begin
            for (int b = 0; b < PW; b++) exp[b] = 8'(k * PW + b);
            checks++;
            if (dat_q[k] !== exp || len_q[k] != 7) begin
                errors++;
                $display("FAIL basic_chunk%0d got=%h/%0d exp=%h/7",
                         k, dat_q[k], len_q[k], exp);
            end
        end
        checks++;
        if (done_out !== 1'b1 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_done done=%0b valid=%0b exp done=1 valid=0",
                     done_out, valid_out);
        end
    endtask

    task automatic test_partial();
        logic [PW-1:0][7:0] exp;
        int bad;
        restart(2, 3, 1'b1);
        drain(80);
        checks++;
        if (len_q.size() != 5) begin
            errors++; $display("FAIL partial_chunks got=%0d exp=5", len_q.size());
        end
        bad = -1;
        for (int k = 0; k < len_q.size(); k++)
            if (len_q[k] != ((k == 4) ? 2 : 3)) bad = k;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL partial_len idx=%0d got=%0d exp=%0d",
                     bad, len_q[bad], (bad == 4) ? 2 : 3);
        end
        exp = '0;
        exp[0] = 8'h0c;
        exp[1] = 8'h0d;
        checks++;
        if (dat_q.size() < 5 || dat_q[4] !== exp) begin
            errors++;
            $display("FAIL partial_last got=%h exp=%h",
                     (dat_q.size() >= 5) ? dat_q[4] : '0, exp);
        end
        bad = -1;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 8'(i)) bad = i;
        checks++;
        if (bad >= 0 || got_q.size() != 14) begin
            errors++;
            $display("FAIL partial_stream size=%0d bad_idx=%0d exp size=14 bad_idx=-1",
                     got_q.size(), bad);
        end
        checks++;
        if (done_out !== 1'b1) begin
            errors++; $display("FAIL partial_done got=%0b exp=1", done_out);
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a1;
        logic [PW-1:0][7:0] exp;
        int bad;
        restart(4, 7, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        a1 = bram_addr;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (a1 !== 10'd2 || bram_addr !== 10'd2) begin
            errors++;
            $display("FAIL stall_addr got=%0d,%0d exp=2,2", a1, bram_addr);
        end
        checks++;
        if (dut.state_q !== HOLD || dut.count !== 4'd14) begin
            errors++;
            $display("FAIL stall_hold state=%0d count=%0d exp state=%0d count=14",
                     dut.state_q, dut.count, HOLD);
        end
        req_len_in = 3'd3;
        #1;
        exp = '0;
        exp[1] = 8'h01;
        exp[2] = 8'h02;
        checks++;
        if (length_out !== 3'd3 || data_out !== exp || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL stall_relen len=%0d data=%h valid=%0b exp len=3 data=%h valid=1",
                     length_out, data_out, valid_out, exp);
        end
        req_len_in = 3'd7;
        ready_in = 1'b1;
        drain(120);
        bad = -1;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 8'(i)) bad = i;
        checks++;
        if (bad >= 0 || got_q.size() != 28) begin
            errors++;
            $display("FAIL stall_stream size=%0d bad_idx=%0d exp size=28 bad_idx=-1",
                     got_q.size(), bad);
        end
        checks++;
        if (done_out !== 1'b1) begin
            errors++; $display("FAIL stall_done got=%0b exp=1", done_out);
        end
    endtask

    task automatic test_overlap();
        logic [PW-1:0][7:0] exp;
        int n;
        int bad;
        restart(3, 1, 1'b0);
        n = 0;
        while (dut.count != 4'd7 && n < 30) begin tick(); n++; end
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        n = 0;
        while (!dut.capture && n < 10) begin tick(); n++; end
        checks++;
        if (dut.capture !== 1'b1 || dut.count !== 4'd6) begin
            errors++;
            $display("FAIL overlap_setup capture=%0b count=%0d exp capture=1 count=6",
                     dut.capture, dut.count);
        end
        req_len_in = 3'd5;
        ready_in = 1'b1;
        tick();
        checks++;
        if (dut.count !== 4'd8) begin
            errors++; $display("FAIL overlap_count got=%0d exp=8", dut.count);
        end
        req_len_in = 3'd7;
        drain(80);
        for (int b = 0; b < PW; b++) exp[b] = 8'(6 + b);
        checks++;
        if (dat_q.size() < 3 || len_q[1] != 5 || dat_q[2] !== exp) begin
            errors++;
            $display("FAIL overlap_boundary chunks=%0d got=%h exp=%h",
                     dat_q.size(), (dat_q.size() >= 3) ? dat_q[2] : '0, exp);
        end
        bad = -1;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 8'(i)) bad = i;
        checks++;
        if (bad >= 0 || got_q.size() != 21) begin
            errors++;
            $display("FAIL overlap_stream size=%0d bad_idx=%0d exp size=21 bad_idx=-1",
                     got_q.size(), bad);
        end
    endtask

    task automatic test_reset_wait();
        logic [PW-1:0][7:0] exp;
        int n;
        int bad;
        restart(3, 7, 1'b0);
        n = 0;
        while (!(bram_addr == 10'd1 && dut.state_q == WAIT) && n < 30) begin
            tick(); n++;
        end
        checks++;
        if (bram_addr !== 10'd1 || dut.state_q !== WAIT) begin
            errors++;
            $display("FAIL rstwait_setup addr=%0d state=%0d exp addr=1 state=%0d",
                     bram_addr, dut.state_q, WAIT);
        end
        rst_in = 1'b1;
        tick();
        checks++;
        if (valid_out !== 1'b0 || data_out !== '0 || length_out !== '0
            || bram_addr !== '0 || done_out !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_clear valid=%0b data=%h len=%0d addr=%0d done=%0b exp all 0",
                     valid_out, data_out, length_out, bram_addr, done_out);
        end
        rst_in = 1'b0;
        ready_in = 1'b1;
        got_q.delete();
        len_q.delete();
        dat_q.delete();
        drain(80);
        exp = word_of(10'd0);
        checks++;
        if (dat_q.size() < 1 || dat_q[0] !== exp) begin
            errors++;
            $display("FAIL rstwait_first got=%h exp=%h",
                     (dat_q.size() >= 1) ? dat_q[0] : '0, exp);
        end
        bad = -1;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 8'(i)) bad = i;
        checks++;
        if (bad >= 0 || got_q.size() != 21 || done_out !== 1'b1) begin
            errors++;
            $display("FAIL rstwait_stream size=%0d bad_idx=%0d done=%0b exp size=21 bad_idx=-1 done=1",
                     got_q.size(), bad, done_out);
        end
    endtask

    task automatic test_wrap();
        int bad;
        logic seen_done;
        restart(1, 7, 1'b1);
        seen_done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done_out) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++; $display("FAIL wrap_done got=1 exp=0");
        end
        checks++;
        if (got_q.size() < 35) begin
            errors++; $display("FAIL wrap_volume got=%0d exp>=35", got_q.size());
        end
        bad = -1;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 8'(i % PW)) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL wrap_stream idx=%0d got=%h exp=%h",
                     bad, got_q[bad], 8'(bad % PW));
        end
        checks++;
        if (bram_addr !== '0) begin
            errors++; $display("FAIL wrap_addr got=%0d exp=0", bram_addr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk_in);
        #1;
        test_reset();
`ifdef MSG_READER_WRAP_EN
        test_wrap();
`else
        test_empty();
        test_basic();
        test_partial();
        test_backpressure();
        test_overlap();
        test_reset_wait();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
